// File: rtl/alu_ctrl_mc.sv
// ALU control unit: decodes aluop/funct into a 4-bit ALU op code behind a
// valid/ready handshake, with a multi-cycle sequencer for mult/div.
module alu_ctrl_mc #(
    parameter int DATA_W    = 32,
    parameter int MD_CYCLES = DATA_W,
    parameter int CNT_W     = $clog2(MD_CYCLES + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       aluop,
    input  logic [5:0]       funct,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       operation,
    output logic             illegal,
    output logic             md_busy,
    output logic             md_step,
    output logic [CNT_W-1:0] md_count
);

    typedef enum logic {
        IDLE,
        BUSY
    } state_e;

    localparam logic [CNT_W-1:0] MD_INIT = CNT_W'(MD_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_e           state_q;
    logic             out_valid_q;
    logic [3:0]       op_q;
    logic             ill_q;
    logic [CNT_W-1:0] cnt_q;

    logic [3:0] dec_op;
    logic       dec_ill;
    logic       dec_md;
    logic       accept;

    // Decode aluop/funct; every path fully defines op, illegal and md flags
    always_comb begin
        dec_op  = 4'b0010;
        dec_ill = 1'b0;
        dec_md  = 1'b0;
        if (aluop == 2'b01) begin
            dec_op = 4'b0110;
        end else if (aluop[1]) begin
            case (funct)
                6'b100000,
                6'b100001: dec_op = 4'b0010;
                6'b100010,
                6'b100011: dec_op = 4'b0110;
                6'b100100: dec_op = 4'b0000;
                6'b100101: dec_op = 4'b0001;
                6'b100110: dec_op = 4'b0011;
                6'b100111: dec_op = 4'b1100;
                6'b101010: dec_op = 4'b0111;
                6'b101011: dec_op = 4'b0101;
                6'b011000,
                6'b011001,
                6'b011010,
                6'b011011: begin
                    dec_op = {2'b10, funct[1:0]};
                    dec_md = 1'b1;
                end
                default: begin
                    dec_op  = 4'b1111;
                    dec_ill = 1'b1;
                end
            endcase
        end
    end

    // Ready only in IDLE with room in the output slot and no abort pending
    always_comb begin
        in_ready = (state_q == IDLE)
                 & (~out_valid_q | out_ready)
                 & ~flush;
        accept   = in_valid & in_ready;
    end

    // Control FSM with registered result, valid flag and iteration counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            op_q        <= 4'b0000;
            ill_q       <= 1'b0;
            cnt_q       <= '0;
        end else if (flush) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        op_q  <= dec_op;
                        ill_q <= dec_ill;
                        if (dec_md) begin
                            state_q     <= BUSY;
                            cnt_q       <= MD_INIT;
                            out_valid_q <= 1'b0;
                        end else begin
                            out_valid_q <= 1'b1;
                        end
                    end else if (out_ready) begin
                        out_valid_q <= 1'b0;
                    end
                end
                BUSY: begin
                    if (cnt_q == CNT_ONE) begin
                        state_q     <= IDLE;
                        cnt_q       <= '0;
                        out_valid_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign operation = op_q;
    assign illegal   = ill_q;
    assign md_busy   = (state_q == BUSY);
    assign md_step   = md_busy;
    assign md_count  = cnt_q;

endmodule

// File: tb/tb_alu_ctrl_mc.sv
// Randomised and directed bench for alu_ctrl_mc against a
// behavioural model of the handshake and mult/div sequencing.
module tb_alu_ctrl_mc;

    localparam int MD = 4;
    localparam int CW = $clog2(MD + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [1:0]    aluop = 2'b00;
    logic [5:0]    funct = 6'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [3:0]    operation;
    logic          illegal;
    logic          md_busy;
    logic          md_step;
    logic [CW-1:0] md_count;

    alu_ctrl_mc #(
        .DATA_W(32),
        .MD_CYCLES(MD)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .flush(flush),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .aluop(aluop),
        .funct(funct),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .operation(operation),
        .illegal(illegal),
        .md_busy(md_busy),
        .md_step(md_step),
        .md_count(md_count)
    );

    always #5 clk = ~clk;

    int errs = 0;
    int checks = 0;

    // Model state: remaining mult/div iterations, held result
    int       m_left = 0;
    bit       m_valid = 1'b0;
    bit [3:0] m_op = 4'h0;
    bit       m_ill = 1'b0;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h t=%0t",
                     tag, got, exp, $time);
        end
    endtask

    // Spec table: returns {illegal, is_muldiv, op}
    function automatic bit [5:0] ref_dec(input bit [1:0] a,
                                         input bit [5:0] f);
        if (a == 2'b00) return {2'b00, 4'h2};
        if (a == 2'b01) return {2'b00, 4'h6};
        case (f)
            6'h20, 6'h21: return {2'b00, 4'h2};
            6'h22, 6'h23: return {2'b00, 4'h6};
            6'h24: return {2'b00, 4'h0};
            6'h25: return {2'b00, 4'h1};
            6'h26: return {2'b00, 4'h3};
            6'h27: return {2'b00, 4'hc};
            6'h2a: return {2'b00, 4'h7};
            6'h2b: return {2'b00, 4'h5};
            6'h18: return {2'b01, 4'h8};
            6'h19: return {2'b01, 4'h9};
            6'h1a: return {2'b01, 4'ha};
            6'h1b: return {2'b01, 4'hb};
            default: return {2'b10, 4'hf};
        endcase
    endfunction

    function automatic bit exp_ready();
        return (m_left == 0) && (!m_valid || out_ready) && !flush;
    endfunction

    task automatic model_reset();
        m_left  = 0;
        m_valid = 1'b0;
        m_op    = 4'h0;
        m_ill   = 1'b0;
    endtask

    task automatic model_edge();
        bit [5:0] d;
        bit acc;
        acc = in_valid && exp_ready();
        if (flush) begin
            m_left  = 0;
            m_valid = 1'b0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) m_valid = 1'b1;
        end else if (acc) begin
            d     = ref_dec(aluop, funct);
            m_op  = d[3:0];
            m_ill = d[5];
            if (d[4]) begin
                m_left  = MD;
                m_valid = 1'b0;
            end else begin
                m_valid = 1'b1;
            end
        end else if (out_ready) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic check_outs();
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("operation", 32'(operation), 32'(m_op));
        chk("illegal", 32'(illegal), 32'(m_ill));
        chk("md_busy", 32'(md_busy), 32'(m_left > 0));
        chk("md_step", 32'(md_step), 32'(m_left > 0));
        chk("md_count", 32'(md_count), 32'(m_left));
        chk("in_ready", 32'(in_ready), 32'(exp_ready()));
    endtask

    // Called just after a negedge: drive, check, take one edge
    task automatic cyc(input bit v, input bit [1:0] a,
                       input bit [5:0] f, input bit r,
                       input bit fl);
        in_valid  = v;
        aluop     = a;
        funct     = f;
        out_ready = r;
        flush     = fl;
        #1;
        check_outs();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    bit [5:0] legal_f [16] = '{6'h20, 6'h21, 6'h22, 6'h23,
                               6'h24, 6'h25, 6'h26, 6'h27,
                               6'h2a, 6'h2b, 6'h18, 6'h19,
                               6'h1a, 6'h1b, 6'h3f, 6'h00};

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        check_outs();

        // Back-to-back decode
        cyc(1, 2'b10, 6'h24, 1, 0);
        chk("b2b_and", 32'(operation), 32'h0);
        cyc(1, 2'b10, 6'h27, 1, 0);
        chk("b2b_nor", 32'(operation), 32'hc);
        cyc(1, 2'b00, 6'h3a, 1, 0);
        chk("b2b_add", 32'(operation), 32'h2);
        cyc(1, 2'b01, 6'h11, 1, 0);
        chk("b2b_sub", 32'(operation), 32'h6);
        chk("b2b_ill", 32'(illegal), 32'd0);

        // Illegal funct
        cyc(1, 2'b10, 6'h3f, 1, 0);
        chk("ill_op", 32'(operation), 32'hf);
        chk("ill_flag", 32'(illegal), 32'd1);
        chk("ill_valid", 32'(out_valid), 32'd1);

        // Mult with MD=4
        cyc(1, 2'b10, 6'h18, 1, 0);
        chk("mult_cnt0", 32'(md_count), 32'd4);
        for (int i = 0; i < MD; i++) begin
            cyc(1, 2'b10, 6'h20, 1, 0);
        end
        chk("mult_done", 32'(out_valid), 32'd1);
        chk("mult_op", 32'(operation), 32'h8);

        // Backpressure after slt
        cyc(1, 2'b10, 6'h2a, 1, 0);
        chk("bp_slt", 32'(operation), 32'h7);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 2'b10, 6'h25, 0, 0);
            chk("bp_hold", 32'(operation), 32'h7);
        end
        cyc(1, 2'b10, 6'h25, 1, 0);
        chk("bp_or", 32'(operation), 32'h1);

        // Flush on second BUSY cycle of divu
        cyc(1, 2'b10, 6'h1b, 1, 0);
        cyc(0, 2'b00, 6'h00, 1, 0);
        cyc(0, 2'b00, 6'h00, 1, 1);
        flush = 1'b0;
        #1;
        chk("fl_busy", 32'(md_busy), 32'd0);
        chk("fl_valid", 32'(out_valid), 32'd0);
        chk("fl_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        cyc(1, 2'b00, 6'h00, 1, 0);
        chk("fl_add", 32'(operation), 32'h2);
        chk("fl_add_v", 32'(out_valid), 32'd1);

        // Async reset mid-BUSY after 2 steps
        cyc(1, 2'b10, 6'h18, 1, 0);
        cyc(0, 2'b00, 6'h00, 1, 0);
        cyc(0, 2'b00, 6'h00, 1, 0);
        #1;
        chk("pre_rst_cnt", 32'(md_count), 32'd2);
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(md_busy), 32'd0);
        chk("arst_step", 32'(md_step), 32'd0);
        chk("arst_cnt", 32'(md_count), 32'd0);
        chk("arst_op", 32'(operation), 32'h0);
        chk("arst_valid", 32'(out_valid), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_ready", 32'(in_ready), 32'd1);
        chk("rel_valid", 32'(out_valid), 32'd0);
        @(negedge clk);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            bit [5:0] f;
            if ($urandom_range(0, 9) < 7)
                f = legal_f[$urandom_range(0, 15)];
            else
                f = 6'($urandom);
            cyc($urandom_range(0, 3) != 0,
                2'($urandom), f,
                $urandom_range(0, 3) != 0,
                $urandom_range(0, 19) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/alu_ctrl_mc.md
Name: alu_ctrl_mc

Overview:
- Next-generation ALU control unit for the MIPS-subset datapath.
- Decodes aluop/funct into a 4-bit ALU operation code and registers it behind a valid/ready handshake.
- Adds the full R-type arithmetic/logic set, an explicit illegal-instruction flag, and a multi-cycle sequencer for mult/div that stalls the front end while the iterative unit runs.
- Sits between the main control decoder and the ALU / mul-div unit.

Parameters:
- DATA_W, 32: datapath width; sets the default mul/div iteration count.
- MD_CYCLES, DATA_W: busy cycles per mult/div. Legal range is 1..256.
- CNT_W, $clog2(MD_CYCLES+1): width of the iteration counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous abort: drops the held result and any busy mult/div.
- in_valid  in  1  aluop/funct valid.
- in_ready  out  1  block can accept a new request.
- aluop  in  2  from main control.
- funct  in  6  instruction funct field.
- out_valid  out  1  operation/illegal hold a completed decode.
- out_ready  in  1  downstream consumes the output.
- operation  out  4  ALU operation code.
- illegal  out  1  the decoded request is not a supported op.
- md_busy  out  1  mult/div iteration in progress.
- md_step  out  1  advance the mul/div unit one iteration.
- md_count  out  CNT_W  remaining iterations, including the current one.

Behaviour:
- Decode:
  - aluop 00 → 0010 (add).
  - aluop 01 → 0110 (sub).
  - aluop 1x → decode the full 6-bit funct:
    - 100000/100001 → 0010 (add)
    - 100010/100011 → 0110 (sub)
    - 100100 → 0000 (and)
    - 100101 → 0001 (or)
    - 100110 → 0011 (xor)
    - 100111 → 1100 (nor)
    - 101010 → 0111 (slt)
    - 101011 → 0101 (sltu)
    - 011000 → 1000 (mult)
    - 011001 → 1001 (multu)
    - 011010 → 1010 (div)
    - 011011 → 1011 (divu)
    - any other funct → 1111, illegal=1.
  - No latching of stale codes: every accepted request fully defines operation.
- Accept rule: a request is accepted on a rising edge with in_valid & in_ready.
- in_ready = (state==IDLE) & (!out_valid | out_ready) & !flush. It is combinational.
- States: IDLE and BUSY.
- IDLE, accepting a single-cycle op or an illegal op:
  - At the same edge: operation/illegal are registered and out_valid=1.
  - Latency is 1 cycle.
  - Sustains 1 request/cycle while out_ready=1.
- IDLE, accepting a mult/div op:
  - Go to BUSY; operation=code, md_count=MD_CYCLES, out_valid=0.
- BUSY:
  - md_busy=1 and md_step=1 every cycle; md_count decrements each edge.
  - On the edge where md_count==1: go to IDLE, md_count=0, out_valid=1.
  - Total latency from accept to out_valid is MD_CYCLES+1 edges.
  - operation stays stable throughout BUSY.
- Output hold:
  - out_valid stays high, with operation/illegal stable, until an edge with out_ready=1.
  - At that edge out_valid clears, unless a new request is accepted at the same edge; then the new single-cycle result loads and out_valid stays 1.
- Simultaneous events:
  - out_ready is ignored when out_valid=0.
  - in_valid is ignored while BUSY.
  - A request presented while out_valid=1 and out_ready=0 is not accepted (in_ready=0).
- flush (synchronous, highest priority after reset):
  - Next state IDLE; out_valid=0, md_busy=0, md_count=0.
  - operation is unchanged; no request is accepted in that cycle.
- Reset (asynchronous, any time including mid-BUSY), all registers cleared immediately:
  - state=IDLE, out_valid=0, operation=0000, illegal=0, md_count=0.
  - Derived outputs follow: md_busy=0, md_step=0.
  - in_ready is 1 after reset (state IDLE, out_valid=0, flush low).
- md_step is combinational and equals md_busy. There is no extra step after completion.

Test Plan:
- Reset: assert rst_n=0 mid-BUSY (MD_CYCLES=4, 2 steps done) → outputs clear asynchronously before the next edge. Release → in_ready=1, out_valid=0.
- Back-to-back decode, out_ready=1:
  - Stimulus: (aluop=10, funct=100100), (10,100111), (00,xxxxxx), (01,xxxxxx) on consecutive cycles.
  - Response: operation 0000, 1100, 0010, 0110 on the following consecutive cycles; illegal=0.
- Illegal decode: (aluop=10, funct=111111) → operation=1111, illegal=1, out_valid=1 after 1 cycle.
- Mult, MD_CYCLES=4:
  - Stimulus: (10, 011000) accepted at edge E0.
  - Response: md_busy=1 for 4 cycles with md_count 4,3,2,1; in_ready=0; out_valid=1 at E4 with operation=1000.
- Backpressure:
  - Stimulus: out_ready=0 for 3 cycles after a slt result (0111), with in_valid held high on (10,100101).
  - Response: in_ready=0 and operation stays 0111 for all 3 cycles. The cycle out_ready=1, or (0001) is accepted and appears on the next cycle.
- Flush: assert flush on the 2nd BUSY cycle of a divu (1011) → next cycle md_busy=0, out_valid=0, in_ready=1. A following add decodes normally.
